serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle subtractor that computes S = A − B one CHUNK-bit slice per cycle and reports carry/overflow flags. It sits directly upstream of the ALU comparators: ComparatorEQ consumes its S output, and the branch logic consumes its flags. It trades latency for a narrow carry chain, and uses a start/done handshake toward the ALU control.

## Interface
Parameters:
- WIDTH, 32, operand and result width.
- CHUNK, 8, bits processed per cycle; WIDTH must be a multiple of CHUNK; N = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when the block is accepting.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; S and the flags are valid.
- S  output  WIDTH  result A − B, modulo 2^WIDTH.
- C  output  1  carry out of A + ~B + 1; 1 = no borrow.
- V  output  1  signed overflow.
- LT  output  1  signed A < B (only with CMP_FLAGS_EN).
- LTU  output  1  unsigned A < B (only with CMP_FLAGS_EN).

## Operation
- Computation: S = A + ~B + 1, evaluated chunk-wise from LSB to MSB. Carry-in for chunk 0 is 1; the carry is registered between chunks.
- States:
  - IDLE: accepting.
  - RUN: chunk counter k = 0..N−1.
  - DONE: accepting; done = 1.
- Transitions:
  - IDLE + start → RUN. Latch A and B into operand registers, set k = 0, set carry = 1.
  - RUN: each cycle writes S[k*CHUNK +: CHUNK] and updates carry. At k = N−1, go to DONE. Otherwise increment k.
  - DONE + start → RUN, with a new capture (back-to-back operation).
  - DONE without start → IDLE.
- start in RUN is ignored: there is no queue and no error.
- A and B may change freely after the accepting edge.
- Flags are registered on the RUN→DONE edge:
  - C = final carry.
  - V = (A[W−1] ^ B[W−1]) & (S[W−1] ^ A[W−1]), computed from the latched operands.
- S and the flags hold their values through IDLE until the next accepted start. S contents during RUN are partial and carry no meaning.
- Reset, at any time including mid-RUN:
  - state = IDLE, k = 0, carry = 0.
  - S = 0, C = V = LT = LTU = 0, busy = 0, done = 0.
  - The in-flight operation is discarded and no done pulse is produced.

## Timing
- A start accepted in cycle t gives busy = 1 in cycles t+1 .. t+N and done = 1 in cycle t+N+1.
- Latency is N+1 cycles; with defaults, done arrives 5 cycles after the start cycle.
- Throughput with back-to-back starts (start asserted during DONE) is one result per N+1 cycles.
- done is never high for two consecutive cycles unless a back-to-back start occurred.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- CMP_FLAGS_EN:
  - Defined: LT and LTU ports exist. They are registered on the RUN→DONE edge with LT = S[W−1] ^ V and LTU = ~C, and follow the same hold and reset rules as C and V.
  - Undefined: the LT and LTU ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default WIDTH and CHUNK constants.
- One sub-module, adder_chunk: a CHUNK-bit combinational adder with cin and cout, instantiated once and fed the selected operand slices.
- The counter width is clog2(N).

## Test plan
- A=0x0000_0005, B=0x0000_0005, start at t → done only in t+5; busy in t+1..t+4; S=0, C=1, V=0, LT=0, LTU=0.
- A=0x0000_0100, B=0x0000_0001 → S=0x0000_00FF, C=1, V=0 (borrow crosses the chunk boundary).
- A=0x0000_0000, B=0x0000_0001 → S=0xFFFF_FFFF, C=0, V=0, LT=1, LTU=1.
- A=0x8000_0000, B=0x0000_0001 → S=0x7FFF_FFFF, C=1, V=1, LT=1, LTU=0.
- Start A=3, B=1 at t, then start with A=9 at t+2 (ignored), then start A=7, B=2 during DONE:
  - first done at t+5 with S=2;
  - second done at t+10 with S=5;
  - no other done pulses.
- Reset asserted at t+2 of an operation:
  - busy, done, S and the flags go to 0 immediately;
  - no done pulse follows;
  - a new start after reset release produces a correct result at +5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and default datapath sizes.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes n slices, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple adder slice with carry in and carry out.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/serial_subtractor.sv
// Chunk-serial subtractor S = A - B with C/V flags and a start/done handshake.
// Optional macro CMP_FLAGS_EN adds the registered LT/LTU comparison outputs.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C,
`ifdef CMP_FLAGS_EN
    output logic             LT,
    output logic             LTU,
`endif
    output logic             V
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               c_q, c_d;
    logic               v_q, v_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef CMP_FLAGS_EN
    logic               lt_q, lt_d;
    logic               ltu_q, ltu_d;
`endif

    logic [CHUNK-1:0]   a_slice, nb_slice, sum;
    logic               cout;
    logic               v_next;

    // Subtraction as A + ~B + 1: the slice of B is inverted, carry_q supplies the +1.
    assign a_slice  = a_q[int'(k_q)*CHUNK +: CHUNK];
    assign nb_slice = ~b_q[int'(k_q)*CHUNK +: CHUNK];

    adder_chunk #(.CHUNK(CHUNK)) u_adder (
        .a    (a_slice),
        .b    (nb_slice),
        .cin  (carry_q),
        .sum  (sum),
        .cout (cout)
    );

    assign v_next = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum[CHUNK-1] ^ a_q[WIDTH-1]);

    always_comb begin
        // NOTE: every _d gets a default up front so no path through the case infers a latch.
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        v_d     = v_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef CMP_FLAGS_EN
        lt_d    = lt_q;
        ltu_d   = ltu_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B;
                    k_d     = '0;
                    carry_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d[int'(k_q)*CHUNK +: CHUNK] = sum;
                carry_d = cout;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    c_d     = cout;
                    v_d     = v_next;
`ifdef CMP_FLAGS_EN
                    lt_d    = sum[CHUNK-1] ^ v_next;
                    ltu_d   = ~cout;
`endif
                end else begin
                    k_d    = k_q + 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CMP_FLAGS_EN
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef CMP_FLAGS_EN
            lt_q    <= lt_d;
            ltu_q   <= ltu_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign C    = c_q;
    assign V    = v_q;
`ifdef CMP_FLAGS_EN
    assign LT   = lt_q;
    assign LTU  = ltu_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors, timing and reset abort.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, C, V;
    logic [31:0] S;
`ifdef CMP_FLAGS_EN
    logic        LT, LTU;
`endif

    serial_subtractor dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .C     (C),
`ifdef CMP_FLAGS_EN
        .LT    (LT),
        .LTU   (LTU),
`endif
        .V     (V)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        lt;
        logic        ltu;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Monitor: every done pulse pops one expectation and checks data, flags and cycle.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("S", S, e.s);
                check("C", {31'b0, C}, {31'b0, e.c});
                check("V", {31'b0, V}, {31'b0, e.v});
`ifdef CMP_FLAGS_EN
                check("LT", {31'b0, LT}, {31'b0, e.lt});
                check("LTU", {31'b0, LTU}, {31'b0, e.ltu});
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; start is sampled on the next edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit push,
                         input logic [31:0] s, input logic c, input logic v,
                         input logic lt, input logic ltu);
        exp_t e;
        start = 1'b1;
        A = a;
        B = b;
        if (push) begin
            e.s = s; e.c = c; e.v = v; e.lt = lt; e.ltu = ltu; e.cyc = cyc + 5;
            exp_q.push_back(e);
        end
        tick(1);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_S", S, 32'd0);
        check("rst_C", {31'b0, C}, 32'd0);
        check("rst_V", {31'b0, V}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Equal operands; busy must cover exactly the four RUN cycles.
        do_op(32'h5, 32'h5, 1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("busy_t%0d", i), {31'b0, busy}, (i <= 4) ? 32'd1 : 32'd0);
            tick(1);
        end
        tick(2);

        // Borrow ripples across the chunk 0 / chunk 1 boundary; S then holds in IDLE.
        do_op(32'h0000_0100, 32'h1, 1, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8);
        @(negedge clk);
        check("hold_S", S, 32'h0000_00FF);
        check("hold_done", {31'b0, done}, 32'd0);
        tick(1);

        do_op(32'h0, 32'h1, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(7);
        do_op(32'h8000_0000, 32'h1, 1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(7);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(7);

        // Start in RUN is ignored; start during DONE runs back-to-back.
        do_op(32'd3, 32'd1, 1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        start = 1'b1;
        A = 32'd9;
        B = 32'd0;
        tick(1);
        start = 1'b0;
        tick(2);
        do_op(32'd7, 32'd2, 1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(8);

        // Reset two cycles into an operation discards it immediately.
        do_op(32'hDEAD_BEEF, 32'h1234_5678, 0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_S", S, 32'd0);
        check("abort_C", {31'b0, C}, 32'd0);
        check("abort_V", {31'b0, V}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(8);

        do_op(32'h1234_5678, 32'h0000_1111, 1, 32'h1234_4567, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
